ad_bus2wb: RTL
==============

AD_BUS2WB -- requirements
Module: ad_bus2wb

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 16, address bus width; DATA_WIDTH, default 16, data width; WQ_DEPTH, default 4, write-queue entries (power of 2); TIMEOUT, default 255, ack-wait limit in clk cycles.
REQ-002 Ports SHALL be, in order: clk in 1, sole clock; resetn in 1, synchronous active-low reset; one clock, with reset sampled on the rising clk edge only.
REQ-003 bus_addr in ADDR_WIDTH, address from SPI stage; bus_wdata in DATA_WIDTH, write data; bus_wr in 1, write level; bus_rd in 1, read level; bus_rdata out DATA_WIDTH, read data returned to SPI stage.
REQ-004 wb_adr_o out ADDR_WIDTH; wb_dat_o out DATA_WIDTH; wb_dat_i in DATA_WIDTH; wb_we_o out 1; wb_sel_o out DATA_WIDTH/8; wb_stb_o out 1; wb_cyc_o out 1; wb_ack_i in 1; these form a Wishbone classic master.
REQ-005 busy out 1, queue non-empty or cycle active; err_ovf out 1, sticky write-drop flag; err_tmo out 1, sticky timeout flag; err_clr in 1, clears both sticky flags.

Function
REQ-006 bus_wr and bus_rd are multi-cycle levels; a request SHALL be the 0->1 transition of each, detected with one registered copy.
REQ-007 On a bus_wr rising edge, the block SHALL push {bus_addr, bus_wdata} sampled one clk later, because write data settles one cycle after bus_wr rises.
REQ-008 When the queue is full at the push cycle, the entry SHALL be dropped and err_ovf set, unless a pop occurs in that same cycle, in which case the push SHALL be accepted.
REQ-009 On a bus_rd rising edge, bus_addr SHALL be captured into a pending-read register; a further bus_rd edge while a read is pending SHALL be ignored.
REQ-010 The FSM SHALL have states IDLE, WRITE and READ; reads SHALL NOT start until the queue is empty, so writes complete in order before any read.
REQ-011 IDLE->WRITE when the queue is non-empty; otherwise IDLE->READ when a read is pending; otherwise the FSM stays in IDLE.
REQ-012 On entry to WRITE or READ, the block SHALL assert wb_cyc_o, wb_stb_o and all wb_sel_o bits, drive wb_adr_o, and set wb_we_o=1 for WRITE or 0 for READ, with wb_dat_o taken from the queue head for WRITE.
REQ-013 On wb_ack_i, the block SHALL deassert stb/cyc on the next edge and return to IDLE; in WRITE it SHALL pop the queue, and in READ it SHALL register wb_dat_i into bus_rdata and clear the pending flag.
REQ-014 Back-to-back cycles SHALL have at least one idle clk with cyc=0 between them.
REQ-015 An 8-bit ack-wait counter SHALL reset on cycle start; if it reaches TIMEOUT without ack, the block SHALL abort the cycle, set err_tmo and return to IDLE.
REQ-016 On a timeout in WRITE, the entry SHALL be popped; on a timeout in READ, bus_rdata SHALL be all ones.
REQ-017 Read latency from the bus_rd edge to bus_rdata valid, with an empty queue and ack on the first stb cycle, SHALL be 4 clk.
REQ-018 bus_rdata SHALL hold its last value until the next read completes.
REQ-019 When err_clr is asserted in the same cycle as a set event, the set SHALL win.

Reset
REQ-020 While resetn=0, the block SHALL go to IDLE, empty the queue, clear the pending read and edge registers, and drive 0 on wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, bus_rdata, busy, err_ovf and err_tmo.
REQ-021 A reset mid-cycle SHALL drop cyc/stb at that edge with no pop and no rdata update.

Structure
REQ-022 A shared definitions package SHALL hold the FSM state encoding (IDLE=0, WRITE=1, READ=2), the default widths and the timeout constant.
REQ-023 The queue SHALL be one sub-module, ad_bus_wr_fifo: a synchronous FIFO with push/pop/full/empty, pointer wrap at WQ_DEPTH, and a count width of log2(WQ_DEPTH)+1.

Verification
REQ-024 Write bus_addr=0x0012, bus_wdata=0xA5A5 with ack after 2 cycles -> exactly one WB write cycle, adr=0x0012, dat=0xA5A5, we=1, sel=2'b11.
REQ-025 Read 0x0040 with wb_dat_i=0x1234 and immediate ack -> bus_rdata=0x1234 4 clk after the bus_rd edge; bus_rd held 20 cycles -> exactly one WB read.
REQ-026 Five writes with ack withheld -> first four queued, fifth dropped, err_ovf=1; after releasing ack, four writes complete in order; err_clr -> err_ovf=0.
REQ-027 Three writes queued, then a read -> all three WB writes precede the WB read.
REQ-028 Read with no ack -> cyc drops after 255 cycles, err_tmo=1, bus_rdata=0xFFFF.
REQ-029 resetn=0 asserted mid write cycle -> cyc/stb=0 at that edge, queue empty, busy=0.

Source files
------------

// File: rtl/ad_bus2wb_pkg.sv
// Shared definitions for the SPI-side bus to Wishbone classic bridge.
// Holds the FSM encoding, default widths and the ack-wait limit.
package ad_bus2wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_e;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_WQ_DEPTH   = 4;
   localparam int DEF_TIMEOUT    = 255;
   localparam int TMO_CNT_W      = 8;

endpackage

// File: rtl/ad_bus_wr_fifo.sv
// Write queue for the bridge: synchronous FIFO, push/pop/full/empty.
// A push while full is taken only when a pop frees a slot that cycle.
module ad_bus_wr_fifo
   import ad_bus2wb_pkg::*;
#(
   parameter int WIDTH = DEF_ADDR_WIDTH + DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_WQ_DEPTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= din;
      end
   end

endmodule

// File: rtl/ad_bus2wb.sv
// Bridge from the SPI stage's level-based bus to a Wishbone classic master.
// Writes are queued and drained in order; a single read waits for an empty queue.
module ad_bus2wb
   import ad_bus2wb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WQ_DEPTH   = DEF_WQ_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [ADDR_WIDTH-1:0]   bus_addr,
   input  logic [DATA_WIDTH-1:0]   bus_wdata,
   input  logic                    bus_wr,
   input  logic                    bus_rd,
   output logic [DATA_WIDTH-1:0]   bus_rdata,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic                    wb_stb_o,
   output logic                    wb_cyc_o,
   input  logic                    wb_ack_i,
   output logic                    busy,
   output logic                    err_ovf,
   output logic                    err_tmo,
   input  logic                    err_clr
);

   localparam int SEL_W  = DATA_WIDTH / 8;
   localparam int FIFO_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  wr_q, wr_d;
   logic                  rd_q, rd_d;
   logic                  wr_push_q, wr_push_d;
   logic                  rd_req_q, rd_req_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [TMO_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  cyc_q, cyc_d;
   logic                  we_q, we_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ovf_q, ovf_d;
   logic                  tmo_q, tmo_d;

   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FIFO_W-1:0]     fifo_head;
   logic                  ovf_set;
   logic                  tmo_set;

   ad_bus_wr_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (WQ_DEPTH)
   ) u_wr_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (wr_push_q),
      .din    ({bus_addr, bus_wdata}),
      .pop    (fifo_pop),
      .dout   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      wr_d      = bus_wr;
      rd_d      = bus_rd;
      wr_push_d = bus_wr & ~wr_q;
      rd_req_d  = bus_rd & ~rd_q;
      rd_pend_d = rd_pend_q;
      rd_addr_d = rd_addr_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rdata_d   = rdata_q;
      fifo_pop  = 1'b0;
      tmo_set   = 1'b0;

      // Address is sampled a cycle after the edge, like the write path.
      if (rd_req_q && !rd_pend_q) begin
         rd_pend_d = 1'b1;
         rd_addr_d = bus_addr;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_WRITE;
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = {SEL_W{1'b1}};
               adr_d   = fifo_head[FIFO_W-1 -: ADDR_WIDTH];
               dat_d   = fifo_head[DATA_WIDTH-1:0];
               cnt_d   = '0;
            end else if (rd_pend_q && !wr_push_q) begin
               state_d = ST_READ;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               sel_d   = {SEL_W{1'b1}};
               adr_d   = rd_addr_q;
               cnt_d   = '0;
            end
         end
         ST_WRITE, ST_READ: begin
            if (wb_ack_i || cnt_q == TMO_LAST) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = '0;
               tmo_set = ~wb_ack_i;
               if (state_q == ST_WRITE) begin
                  fifo_pop = 1'b1;
               end else begin
                  rdata_d   = wb_ack_i ? wb_dat_i : {DATA_WIDTH{1'b1}};
                  rd_pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ovf_set = wr_push_q & fifo_full & ~fifo_pop;
      ovf_d   = (ovf_q & ~err_clr) | ovf_set;
      tmo_d   = (tmo_q & ~err_clr) | tmo_set;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         wr_push_q <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         cnt_q     <= '0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         rdata_q   <= '0;
         ovf_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         wr_push_q <= wr_push_d;
         rd_req_q  <= rd_req_d;
         rd_pend_q <= rd_pend_d;
         rd_addr_q <= rd_addr_d;
         cnt_q     <= cnt_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rdata_q   <= rdata_d;
         ovf_q     <= ovf_d;
         tmo_q     <= tmo_d;
      end
   end

   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_sel_o  = sel_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign bus_rdata = rdata_q;
   assign err_ovf   = ovf_q;
   assign err_tmo   = tmo_q;
   assign busy      = cyc_q | ~fifo_empty;

endmodule
